// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity mode codes and transmit FSM state encoding.
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/usrt_sync_fifo.sv
// Synchronous FIFO with registered occupancy count, full/empty/level status
// and a one-cycle overflow pulse when a push is dropped.
// Handshake: push_i is accepted only when full_o is low; pop_i is honoured
// only when empty_o is low; both are judged on the registered count, so a pop
// in the same cycle never makes room for a push that arrives while full.
module usrt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic             ovf_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign ovf_o   = ovf_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next pointers/count; the count alone tells full from empty when pointers meet.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push_i & full_o;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + LVL_W'(1);
        else if (!push_ok && pop_ok) count_d = count_q - LVL_W'(1);
    end

    // Pointer, count and overflow-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/usrt_tx_engine.sv
// USRT transmit path: TX FIFO feeding a frame shifter that emits
// start, DATA_W data bits LSB first, optional parity and 1 or 2 stop bits,
// one bit per baud tick, with back-to-back frames when more data is queued.
module usrt_tx_engine
    import usrt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = 3
) (
    input  logic              i_Pclk,
    input  logic              i_Preset,
    input  logic              i_Bclk,
    input  logic [1:0]        i_Parity,
    input  logic              i_Stop2,
    input  logic              i_Push,
    input  logic [DATA_W-1:0] i_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [LVL_W-1:0]  o_Level,
    output logic              o_Ovf,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Tx_Serial,
    output logic [2:0]        o_Dbg_State
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]        par_mode_q, par_mode_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic              pop;
    logic              load;
    logic              end_frame;
    logic              par_en;
    logic              par_bit;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;

    usrt_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i   (i_Pclk),
        .rst_i   (i_Preset),
        .push_i  (i_Push),
        .data_i  (i_Data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (o_Full),
        .empty_o (fifo_empty),
        .level_o (o_Level),
        .ovf_o   (o_Ovf)
    );

    assign o_Empty     = fifo_empty;
    assign o_Busy      = (state_q != ST_IDLE);
    assign o_Done      = done_q;
    assign o_Tx_Serial = tx_q;
    assign o_Dbg_State = state_q;

    // Parity comes straight from the latched word; mode 11 behaves as none.
    assign par_en  = (par_mode_q == PAR_ODD) || (par_mode_q == PAR_EVEN);
    assign par_bit = (par_mode_q == PAR_ODD) ? ~(^word_q) : (^word_q);

    // Next-state and line value; everything holds unless a baud tick is present.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        end_frame  = 1'b0;

        if (i_Bclk) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) load = 1'b1;
                end
                ST_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_q < CNT_W'(DATA_W)) begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (par_en) begin
                        tx_d    = par_bit;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP1;
                end
                ST_STOP1: begin
                    if (stop2_q) state_d = ST_STOP2;
                    else         end_frame = 1'b1;
                end
                ST_STOP2: begin
                    end_frame = 1'b1;
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Final stop bit finished: chain straight into the next word if one is queued.
        if (end_frame) begin
            done_d = 1'b1;
            if (!fifo_empty) begin
                load = 1'b1;
            end else begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // Frame start: pop the head word and freeze the line configuration.
        if (load) begin
            pop        = 1'b1;
            word_d     = fifo_data;
            shift_d    = fifo_data;
            bit_cnt_d  = '0;
            par_mode_d = i_Parity;
            stop2_d    = i_Stop2;
            tx_d       = 1'b0;
            state_d    = ST_START;
        end
    end

    // Frame state registers; reset aborts any frame and returns the line high.
    always_ff @(posedge i_Pclk) begin
        if (i_Preset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

endmodule
